lt24_frame_scheduler: RTL

- Sequences full-frame redraws of the LT24 panel.
- Walks pixel addresses and fetches each colour from the graphics block.
- Drives the LT24Display pixel write handshake.
- Issues a one-cycle game_tick after each completed frame, so game state (ball, paddles) updates only between frames and never tears mid-frame.
- Replaces the free-running x/y address counters and the separate game clock divider in the top level.

---
 rtl/lt24_frame_scheduler_pkg.sv | 54 +++++
 rtl/lt24_frame_scheduler_if.sv | 33 +++
 rtl/lt24_frame_scheduler_tick_gen.sv | 40 ++++
 rtl/lt24_frame_scheduler.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lt24_frame_scheduler_pkg.sv
// ============================================================================
// Module      : pong_pkg
// Description : Types and constants shared by the LT24 frame scheduler:
//               FSM state encoding, RGB565 bar colours and address widths.
//               The colour-bar helper is used when PONG_TEST_PATTERN_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pong_pkg;

  // Panel address widths (240 columns, 320 rows)
  localparam int X_W = 8;
  localparam int Y_W = 9;

  typedef logic [15:0] rgb565_t;

  // Scheduler FSM encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // RGB565 colours, in colour-bar order
  localparam rgb565_t RGB_WHITE   = 16'hFFFF;
  localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
  localparam rgb565_t RGB_CYAN    = 16'h07FF;
  localparam rgb565_t RGB_GREEN   = 16'h07E0;
  localparam rgb565_t RGB_MAGENTA = 16'hF81F;
  localparam rgb565_t RGB_RED     = 16'hF800;
  localparam rgb565_t RGB_BLUE    = 16'h001F;
  localparam rgb565_t RGB_BLACK   = 16'h0000;

  // Colour of vertical bar idx (0 = leftmost)
  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    rgb565_t c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lt24_frame_scheduler_if.sv
// ============================================================================
// Module      : lt24_frame_scheduler_if
// Description : Graphics fetch port and LT24 pixel-write handshake.
//               master = scheduler side, slave = graphics/display side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lt24_frame_scheduler_if;
  import pong_pkg::*;

  logic [X_W-1:0] gfx_x;
  logic [Y_W-1:0] gfx_y;
  rgb565_t        gfx_rgb;
  logic [X_W-1:0] x_addr;
  logic [Y_W-1:0] y_addr;
  rgb565_t        pixel_data;
  logic           pixel_write;
  logic           pixel_ready;

  modport master (
    output gfx_x, gfx_y, x_addr, y_addr, pixel_data, pixel_write,
    input  gfx_rgb, pixel_ready
  );

  modport slave (
    input  gfx_x, gfx_y, x_addr, y_addr, pixel_data, pixel_write,
    output gfx_rgb, pixel_ready
  );

endinterface

`default_nettype wire

// File: rtl/lt24_frame_scheduler_tick_gen.sv
// ============================================================================
// Module      : frame_tick_gen
// Description : Free-running frame-period counter. frame_tick is high for
//               the one cycle in which the count equals
//               CLOCK_FREQ/FRAME_RATE - 1; the count then wraps to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_tick_gen #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int FRAME_RATE = 30
) (
  input  logic clock,
  input  logic reset_n,
  output logic frame_tick
);

  localparam int TICK_MAX = CLOCK_FREQ / FRAME_RATE - 1;
  localparam int CNT_W    = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_MAX);

  logic [CNT_W-1:0] count;

  // Count 0..TICK_LAST and wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == TICK_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign frame_tick = (count == TICK_LAST);

endmodule

`default_nettype wire

// File: rtl/lt24_frame_scheduler.sv
// ============================================================================
// Module      : lt24_frame_scheduler
// Description : Full-frame redraw sequencer for the LT24 panel. Walks the
//               pixel grid, fetches each colour from graphics (1-cycle
//               latency), drives the pixel write handshake and pulses
//               game_tick once per completed frame so game state only
//               changes between frames.
//               Optional: PONG_TEST_PATTERN_EN adds test_pattern, which
//               replaces the fetched colour with 8 vertical colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lt24_frame_scheduler
  import pong_pkg::*;
#(
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320,
  parameter int CLOCK_FREQ = 50000000,
  parameter int FRAME_RATE = 30
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   draw_enable,
`ifdef PONG_TEST_PATTERN_EN
  input  logic                   test_pattern,
`endif
  lt24_frame_scheduler_if.master bus,
  output logic                   game_tick,
  output logic                   frame_busy,
  output logic                   frame_overrun,
  output logic [15:0]            frame_count
);

  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  logic [2:0]     state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [X_W-1:0] gfx_x_hold;
  logic [Y_W-1:0] gfx_y_hold;
  logic           pending;
  logic           frame_tick;
  logic           start_frame;
  rgb565_t        capture_rgb;

  frame_tick_gen #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .FRAME_RATE (FRAME_RATE)
  ) u_tick (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_tick (frame_tick)
  );

  // A queued frame only starts while drawing is permitted
  assign start_frame = (state == ST_IDLE) && pending && draw_enable;

  // Address is live during FETCH so graphics can register the colour
  // on the FETCH edge; it holds its last value otherwise.
  assign bus.gfx_x = (state == ST_FETCH) ? x : gfx_x_hold;
  assign bus.gfx_y = (state == ST_FETCH) ? y : gfx_y_hold;

`ifdef PONG_TEST_PATTERN_EN
  localparam logic [X_W+2:0] WIDTH_DIV = (X_W + 3)'(WIDTH);
  logic [2:0] bar_idx;
  assign bar_idx = 3'({x, 3'b000} / WIDTH_DIV);
  assign capture_rgb = test_pattern ? bar_colour(bar_idx) : bus.gfx_rgb;
`else
  assign capture_rgb = bus.gfx_rgb;
`endif

  // Pending-frame flag: one queued frame at most, overrun when a second
  // tick arrives before the first was consumed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      frame_overrun <= 1'b0;
      if (!draw_enable) begin
        pending <= 1'b0;
      end else if (frame_tick) begin
        pending <= 1'b1;
        if (pending && !start_frame) begin
          frame_overrun <= 1'b1;
        end
      end else if (start_frame) begin
        pending <= 1'b0;
      end
    end
  end

  // Frame FSM: address walk, colour capture and write handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      x               <= '0;
      y               <= '0;
      gfx_x_hold      <= '0;
      gfx_y_hold      <= '0;
      bus.x_addr      <= '0;
      bus.y_addr      <= '0;
      bus.pixel_data  <= '0;
      bus.pixel_write <= 1'b0;
      game_tick       <= 1'b0;
      frame_busy      <= 1'b0;
      frame_count     <= '0;
    end else begin
      game_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_frame) begin
            x          <= '0;
            y          <= '0;
            frame_busy <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          gfx_x_hold <= x;
          gfx_y_hold <= y;
          state      <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          bus.pixel_data  <= capture_rgb;
          bus.x_addr      <= x;
          bus.y_addr      <= y;
          bus.pixel_write <= 1'b1;
          state           <= ST_WRITE;
        end
        ST_WRITE: begin
          if (bus.pixel_ready) begin
            bus.pixel_write <= 1'b0;
            if (x == X_LAST) begin
              x <= '0;
              if (y == Y_LAST) begin
                game_tick <= 1'b1;
                state     <= ST_DONE;
              end else begin
                y     <= y + Y_W'(1);
                state <= ST_FETCH;
              end
            end else begin
              x     <= x + X_W'(1);
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          frame_count <= frame_count + 16'd1;
          frame_busy  <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
